// File: rtl/key_debounce.sv
// key_debounce: synchronizes, debounces and decodes one active-low key into level and event pulses
module key_debounce #(
    parameter logic [15:0] DB_MS   = 16'd20,
    parameter logic [15:0] LONG_MS = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_1K,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    state_t state_q, state_d;
    logic key_meta_q, key_s_q, clk_1k_q;
    logic [15:0] db_cnt_q, db_cnt_d, long_cnt_q, long_cnt_d;
    logic long_done_q, long_done_d;
    logic key_state_q, key_press_q, key_release_q, key_long_q;
    logic press_d, release_d, long_d;
    logic tick, pressed;
    assign pressed = ~key_s_q;
    assign tick = clk_1K & ~clk_1k_q;
    assign key_state = key_state_q;
    assign key_press = key_press_q;
    assign key_release = key_release_q;
    assign key_long = key_long_q;
    // two-flop key synchronizer (idles released) and clk_1K edge-detect register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_q <= 1'b1;
            key_s_q <= 1'b1;
            clk_1k_q <= 1'b0;
        end else begin
            key_meta_q <= key_n;
            key_s_q <= key_meta_q;
            clk_1k_q <= clk_1K;
        end
    end
    // FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            db_cnt_q <= '0;
            long_cnt_q <= '0;
            long_done_q <= 1'b0;
            key_state_q <= 1'b0;
            key_press_q <= 1'b0;
            key_release_q <= 1'b0;
            key_long_q <= 1'b0;
        end else begin
            state_q <= state_d;
            db_cnt_q <= db_cnt_d;
            long_cnt_q <= long_cnt_d;
            long_done_q <= long_done_d;
            key_state_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            key_press_q <= press_d;
            key_release_q <= release_d;
            key_long_q <= long_d;
        end
    end
    // next state: a level change is checked before the tick so a bouncing tick never counts
    always_comb begin
        state_d = state_q;
        db_cnt_d = db_cnt_q;
        long_cnt_d = long_cnt_q;
        long_done_d = long_done_q;
        press_d = 1'b0;
        release_d = 1'b0;
        long_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    db_cnt_d = '0;
                end else if (tick) begin
                    if (db_cnt_q == DB_MS - 16'd1) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        db_cnt_d = '0;
                        long_cnt_d = '0;
                        long_done_d = 1'b0;
                    end else begin
                        db_cnt_d = db_cnt_q + 16'd1;
                    end
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    db_cnt_d = '0;
                end else if (tick && !long_done_q) begin
                    if (long_cnt_q == LONG_MS - 16'd1) begin
                        long_d = 1'b1;
                        long_done_d = 1'b1;
                    end else begin
                        long_cnt_d = long_cnt_q + 16'd1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = PRESSED;
                end else if (tick) begin
                    if (db_cnt_q == DB_MS - 16'd1) begin
                        state_d = IDLE;
                        release_d = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed vectors and timed sequences for the key debouncer
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_1K = 1'b0;
    logic key_n = 1'b0;
    logic key_state, key_press, key_release, key_long;
    int errors = 0;
    int checks = 0;
    int ecyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0, multi = 0;
    int t_press = -1, t_rel = -1, t_long = -1, t_up = -1, t_dn = -1;
    logic prev_state = 1'b0;

    typedef struct {
        logic key_n;
        int cycles;
        int d_press;
        int d_rel;
        int d_long;
        logic state;
    } vec_t;
    vec_t vecs[19];

    key_debounce #(.DB_MS(16'd3), .LONG_MS(16'd8)) dut (
        .clk(clk),
        .reset(rst),
        .clk_1K(clk_1K),
        .key_n(key_n),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    always #5 clk = ~clk;

    // clk_1K toggles every 5 clk cycles: one tick per 10 cycles
    initial forever begin
        repeat (5) @(negedge clk);
        clk_1K = ~clk_1K;
    end

    // sample outputs 1 time unit after every active edge
    initial forever begin
        @(posedge clk);
        #1;
        ecyc++;
        if (key_press) begin n_press++; t_press = ecyc; end
        if (key_release) begin n_rel++; t_rel = ecyc; end
        if (key_long) begin n_long++; t_long = ecyc; end
        if (int'(key_press) + int'(key_release) + int'(key_long) > 1) multi++;
        if (key_state && !prev_state) t_up = ecyc;
        if (!key_state && prev_state) t_dn = ecyc;
        prev_state = key_state;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int base, p0, r0, l0;
        for (int i = 0; i < 14; i++) vecs[i] = '{logic'(i % 2), 7, 0, 0, 0, 1'b0};
        vecs[14] = '{1'b1, 30, 0, 0, 0, 1'b0};
        vecs[15] = '{1'b0, 50, 1, 0, 0, 1'b1};
        vecs[16] = '{1'b1, 15, 0, 0, 0, 1'b1};
        vecs[17] = '{1'b0, 10, 0, 0, 0, 1'b1};
        vecs[18] = '{1'b1, 50, 0, 1, 0, 1'b0};
        // reset held with key pressed
        repeat (3) @(negedge clk);
        chk("rst_state", key_state, 0);
        chk("rst_press", key_press, 0);
        chk("rst_release", key_release, 0);
        chk("rst_long", key_long, 0);
        // release reset on a clk_1K rising edge: press lands 31 samples later
        @(posedge clk_1K);
        rst = 1'b0;
        base = ecyc;
        repeat (200) @(negedge clk);
        chk("press_time", t_press, base + 31);
        chk("state_up_time", t_up, base + 31);
        chk("press_count", n_press, 1);
        chk("long_time", t_long, base + 111);
        chk("long_count", n_long, 1);
        chk("held_state", key_state, 1);
        // aligned release: key_release and key_state fall 31 samples later
        @(posedge clk_1K);
        key_n = 1'b1;
        base = ecyc;
        repeat (60) @(negedge clk);
        chk("release_time", t_rel, base + 31);
        chk("state_dn_time", t_dn, base + 31);
        chk("release_count", n_rel, 1);
        chk("long_no_repeat", n_long, 1);
        // bounce rejection, clean press, release glitch, clean release
        foreach (vecs[i]) begin
            p0 = n_press;
            r0 = n_rel;
            l0 = n_long;
            key_n = vecs[i].key_n;
            repeat (vecs[i].cycles) @(negedge clk);
            chk($sformatf("vec%0d_press", i), n_press - p0, vecs[i].d_press);
            chk($sformatf("vec%0d_release", i), n_rel - r0, vecs[i].d_rel);
            chk($sformatf("vec%0d_long", i), n_long - l0, vecs[i].d_long);
            chk($sformatf("vec%0d_state", i), key_state, vecs[i].state);
        end
        // reset while held, short of the long-press threshold
        p0 = n_press;
        key_n = 1'b0;
        repeat (95) @(negedge clk);
        chk("hold_press", n_press - p0, 1);
        chk("hold_state", key_state, 1);
        r0 = n_rel;
        l0 = n_long;
        #2 rst = 1'b1;
        #1 chk("async_rst_state", key_state, 0);
        @(negedge clk);
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("rst_no_release", n_rel - r0, 0);
        chk("rst_no_long", n_long - l0, 0);
        chk("rst_after_state", key_state, 0);
        chk("pulse_exclusive", multi, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
